// File: rtl/fifo_wr_arb.sv
// -----------------------------------------------------------------------------
// fifo_wr_arb
// Packet-granular round-robin arbiter in front of a single FIFO write port.
// An idle arbiter picks one requester (round-robin from r_ptr), locks onto it
// for a whole packet and forwards its beats to the FIFO. It releases the lock
// after the beat flagged I_last has been accepted.
//
// Ports
//   I_clk      in   1            FIFO write clock
//   I_rst      in   1            asynchronous active-high reset
//   I_req      in   NREQ         per-requester data valid
//   I_data     in   NREQ*DSIZE   per-requester data, requester k at [k*DSIZE +: DSIZE]
//   I_last     in   NREQ         per-requester last beat of packet (qualified by I_req)
//   O_ack      out  NREQ         one-hot beat-accepted strobe
//   O_grant    out  NREQ         one-hot current owner, zero when idle
//   O_winc     out  1            FIFO write increment
//   O_wdata    out  DSIZE        FIFO write data
//   I_wfull    in   1            FIFO full flag (same clock domain)
//   O_wr_cnt   out  16           accepted beat counter (wraps)
//   O_pkt_cnt  out  16           completed packet counter (wraps)
// -----------------------------------------------------------------------------
module fifo_wr_arb #(
    parameter int NREQ  = 4,
    parameter int DSIZE = 8
) (
    input  logic                  I_clk,
    input  logic                  I_rst,
    input  logic [NREQ-1:0]       I_req,
    input  logic [NREQ*DSIZE-1:0] I_data,
    input  logic [NREQ-1:0]       I_last,
    output logic [NREQ-1:0]       O_ack,
    output logic [NREQ-1:0]       O_grant,
    output logic                  O_winc,
    output logic [DSIZE-1:0]      O_wdata,
    input  logic                  I_wfull,
    output logic [15:0]           O_wr_cnt,
    output logic [15:0]           O_pkt_cnt
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    logic [0:0]       r_state;
    logic [NREQ-1:0]  r_grant;
    logic [PW-1:0]    r_owner;
    logic [PW-1:0]    r_ptr;
    logic [15:0]      r_wr_cnt;
    logic [15:0]      r_pkt_cnt;

    logic             w_found;
    logic [PW-1:0]    w_win_idx;
    logic [PW-1:0]    w_cand;
    logic             w_own_req;
    logic             w_own_last;
    logic [DSIZE-1:0] w_own_data;
    logic             w_lock;
    logic             w_winc;
    logic             w_done;

    // Round-robin search: first requester at or after r_ptr, wrapping at NREQ.
    always_comb begin
        w_found   = 1'b0;
        w_win_idx = '0;
        w_cand    = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_cand = PW'((int'(r_ptr) + i) % NREQ);
            if (!w_found && I_req[w_cand]) begin
                w_found   = 1'b1;
                w_win_idx = w_cand;
            end else begin
                w_found   = w_found;
            end
        end
    end

    // Pick the owner's request, last flag and data slice.
    always_comb begin
        w_own_req  = 1'b0;
        w_own_last = 1'b0;
        w_own_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (r_owner == PW'(k)) begin
                w_own_req  = I_req[k];
                w_own_last = I_last[k];
                w_own_data = I_data[k*DSIZE +: DSIZE];
            end else begin
                w_own_req  = w_own_req;
            end
        end
    end

    // Write path is combinational so a beat is accepted in the cycle it is
    // presented; full and a dropped request both simply stall the owner.
    assign w_lock = (r_state == ST_LOCK);
    assign w_winc = w_lock & w_own_req & ~I_wfull;
    assign w_done = w_winc & w_own_last;

    assign O_winc    = w_winc;
    assign O_ack     = r_grant & {NREQ{w_winc}};
    assign O_wdata   = w_lock ? w_own_data : {DSIZE{1'b0}};
    assign O_grant   = r_grant;
    assign O_wr_cnt  = r_wr_cnt;
    assign O_pkt_cnt = r_pkt_cnt;

    // Arbitration FSM: IDLE grants a winner, LOCK holds it until the last beat.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_owner <= '0;
            r_ptr   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_state <= ST_LOCK;
                        r_grant <= {{(NREQ-1){1'b0}}, 1'b1} << w_win_idx;
                        r_owner <= w_win_idx;
                    end
                end
                ST_LOCK: begin
                    if (w_done) begin
                        r_state <= ST_IDLE;
                        r_grant <= '0;
                        r_ptr   <= (r_owner == PW'(NREQ-1)) ? '0 : r_owner + PW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

    // Beat and packet counters, free-running with natural 16-bit wrap.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            r_wr_cnt  <= 16'd0;
            r_pkt_cnt <= 16'd0;
        end else begin
            if (w_winc) begin
                r_wr_cnt <= r_wr_cnt + 16'd1;
            end
            if (w_done) begin
                r_pkt_cnt <= r_pkt_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arb.sv
module tb_fifo_wr_arb;

    logic        I_clk = 1'b0;
    logic        I_rst;
    logic [3:0]  I_req;
    logic [31:0] I_data;
    logic [3:0]  I_last;
    logic [3:0]  O_ack;
    logic [3:0]  O_grant;
    logic        O_winc;
    logic [7:0]  O_wdata;
    logic        I_wfull;
    logic [15:0] O_wr_cnt;
    logic [15:0] O_pkt_cnt;

    fifo_wr_arb #(.NREQ(4), .DSIZE(8)) dut (
        .I_clk(I_clk), .I_rst(I_rst), .I_req(I_req), .I_data(I_data),
        .I_last(I_last), .O_ack(O_ack), .O_grant(O_grant), .O_winc(O_winc),
        .O_wdata(O_wdata), .I_wfull(I_wfull), .O_wr_cnt(O_wr_cnt),
        .O_pkt_cnt(O_pkt_cnt)
    );

    always #5 I_clk = ~I_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // requester model: requester k sends len[k] beats, beat b carries k*16+b
    int         len [4];
    int         sent[4];
    logic [3:0] hold;
    logic       full;
    int         cyc;
    int         viol = 0;
    bit         log_en;

    logic       s_winc;
    logic [3:0] s_grant;
    logic [3:0] s_ack;
    logic [7:0] s_wdata;

    logic [7:0] log_d[$];
    logic [3:0] log_g[$];
    logic [3:0] log_a[$];
    int         log_c[$];

    task automatic apply_inputs();
        for (int k = 0; k < 4; k++) begin
            I_req[k]            = (sent[k] < len[k]) && !hold[k];
            I_data[k*8 +: 8]    = 8'(k*16 + sent[k]);
            I_last[k]           = (sent[k] == len[k] - 1);
        end
        I_wfull = full;
    endtask

    task automatic clear_model();
        for (int k = 0; k < 4; k++) begin
            len[k]  = 0;
            sent[k] = 0;
        end
        hold = 4'b0000;
        full = 1'b0;
        cyc  = 0;
        log_en = 1'b1;
        log_d.delete(); log_g.delete(); log_a.delete(); log_c.delete();
        apply_inputs();
    endtask

    // one clock: present inputs, sample at negedge, requester advances on ack
    task automatic tick();
        apply_inputs();
        @(negedge I_clk);
        s_winc  = O_winc;
        s_grant = O_grant;
        s_ack   = O_ack;
        s_wdata = O_wdata;
        if (O_winc && I_wfull) viol++;
        if (O_winc && log_en) begin
            log_d.push_back(O_wdata);
            log_g.push_back(O_grant);
            log_a.push_back(O_ack);
            log_c.push_back(cyc);
        end
        @(posedge I_clk);
        #1;
        if (s_winc) begin
            for (int k = 0; k < 4; k++) if (s_ack[k]) sent[k]++;
        end
        cyc++;
        apply_inputs();
    endtask

    task automatic test_reset();
        I_rst = 1'b1;
        clear_model();
        #12;
        n_tests++;
        if ({O_grant, O_ack, O_winc, O_wdata, O_wr_cnt, O_pkt_cnt} !== 45'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected 0", {O_grant, O_ack, O_winc, O_wdata, O_wr_cnt, O_pkt_cnt});
        end
        @(posedge I_clk);
        #1;
        I_rst = 1'b0;
        #1;
        n_tests++;
        if ({O_grant, O_winc} !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_release: got %h expected 0", {O_grant, O_winc});
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] ed[8] = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31};
        logic [3:0] eg[8] = '{4'h1, 4'h1, 4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8};
        int         ec[8] = '{1, 2, 4, 5, 7, 8, 10, 11};
        int         guard = 0;
        clear_model();
        for (int k = 0; k < 4; k++) len[k] = 2;
        while ((sent[0] < 2 || sent[1] < 2 || sent[2] < 2 || sent[3] < 2) && guard < 40) begin
            tick();
            guard++;
        end
        n_tests++;
        if (log_d.size() != 8 || cyc != 12) begin
            n_fail++;
            $display("FAIL rr_writes: got %0d writes in %0d cycles expected 8 in 12", log_d.size(), cyc);
        end
        for (int i = 0; i < 8; i++) begin
            if (i < log_d.size()) begin
                n_tests++;
                if ({log_g[i], log_a[i], log_d[i], 8'(log_c[i])} !== {eg[i], eg[i], ed[i], 8'(ec[i])}) begin
                    n_fail++;
                    $display("FAIL rr_beat%0d: got %h expected %h", i,
                             {log_g[i], log_a[i], log_d[i], 8'(log_c[i])}, {eg[i], eg[i], ed[i], 8'(ec[i])});
                end
            end
        end
        n_tests++;
        if ({O_grant, O_wr_cnt, O_pkt_cnt} !== {4'h0, 16'd8, 16'd4}) begin
            n_fail++;
            $display("FAIL rr_counts: got %h expected %h", {O_grant, O_wr_cnt, O_pkt_cnt}, {4'h0, 16'd8, 16'd4});
        end
    endtask

    task automatic test_full_stall();
        logic [7:0] ed[3] = '{8'h20, 8'h21, 8'h22};
        int         ec[3] = '{1, 7, 8};
        clear_model();
        len[2] = 3;
        tick();
        tick();
        full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_tests++;
            if ({s_winc, s_grant, s_ack} !== {1'b0, 4'b0100, 4'b0000}) begin
                n_fail++;
                $display("FAIL full_stall%0d: got %h expected %h", i, {s_winc, s_grant, s_ack}, {1'b0, 4'b0100, 4'b0000});
            end
        end
        full = 1'b0;
        tick();
        tick();
        n_tests++;
        if (log_d.size() != 3 || viol != 0) begin
            n_fail++;
            $display("FAIL full_writes: got %0d writes %0d full-violations expected 3 and 0", log_d.size(), viol);
        end
        for (int i = 0; i < 3; i++) begin
            if (i < log_d.size()) begin
                n_tests++;
                if ({log_g[i], log_a[i], log_d[i], 8'(log_c[i])} !== {4'h4, 4'h4, ed[i], 8'(ec[i])}) begin
                    n_fail++;
                    $display("FAIL full_beat%0d: got %h expected %h", i,
                             {log_g[i], log_a[i], log_d[i], 8'(log_c[i])}, {4'h4, 4'h4, ed[i], 8'(ec[i])});
                end
            end
        end
    endtask

    task automatic test_req_drop();
        logic [7:0] ed[5] = '{8'h10, 8'h11, 8'h12, 8'h00, 8'h01};
        logic [3:0] eg[5] = '{4'h2, 4'h2, 4'h2, 4'h1, 4'h1};
        int         ec[5] = '{1, 6, 7, 9, 10};
        int         guard = 0;
        clear_model();
        len[1] = 3;
        tick();
        len[0] = 2;
        tick();
        hold[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++;
            if ({s_winc, s_grant, s_ack} !== {1'b0, 4'b0010, 4'b0000}) begin
                n_fail++;
                $display("FAIL drop_hold%0d: got %h expected %h", i, {s_winc, s_grant, s_ack}, {1'b0, 4'b0010, 4'b0000});
            end
        end
        hold[1] = 1'b0;
        while ((sent[0] < 2 || sent[1] < 3) && guard < 20) begin
            tick();
            guard++;
        end
        n_tests++;
        if (log_d.size() != 5) begin
            n_fail++;
            $display("FAIL drop_writes: got %0d expected 5", log_d.size());
        end
        for (int i = 0; i < 5; i++) begin
            if (i < log_d.size()) begin
                n_tests++;
                if ({log_g[i], log_a[i], log_d[i], 8'(log_c[i])} !== {eg[i], eg[i], ed[i], 8'(ec[i])}) begin
                    n_fail++;
                    $display("FAIL drop_beat%0d: got %h expected %h", i,
                             {log_g[i], log_a[i], log_d[i], 8'(log_c[i])}, {eg[i], eg[i], ed[i], 8'(ec[i])});
                end
            end
        end
        n_tests++;
        if ({O_wr_cnt, O_pkt_cnt} !== {16'd16, 16'd7}) begin
            n_fail++;
            $display("FAIL drop_counts: got %h expected %h", {O_wr_cnt, O_pkt_cnt}, {16'd16, 16'd7});
        end
    endtask

    task automatic test_ptr_wrap();
        logic [7:0] ed[3] = '{8'h30, 8'h00, 8'h30};
        logic [3:0] eg[3] = '{4'h8, 4'h1, 4'h8};
        int         ec[3] = '{1, 3, 5};
        int         guard = 0;
        clear_model();
        len[3] = 1;
        tick();
        tick();
        sent[3] = 0;
        len[0]  = 1;
        while ((sent[0] < 1 || sent[3] < 1) && guard < 20) begin
            tick();
            guard++;
        end
        n_tests++;
        if (log_d.size() != 3) begin
            n_fail++;
            $display("FAIL wrap_writes: got %0d expected 3", log_d.size());
        end
        for (int i = 0; i < 3; i++) begin
            if (i < log_d.size()) begin
                n_tests++;
                if ({log_g[i], log_a[i], log_d[i], 8'(log_c[i])} !== {eg[i], eg[i], ed[i], 8'(ec[i])}) begin
                    n_fail++;
                    $display("FAIL wrap_beat%0d: got %h expected %h", i,
                             {log_g[i], log_a[i], log_d[i], 8'(log_c[i])}, {eg[i], eg[i], ed[i], 8'(ec[i])});
                end
            end
        end
        n_tests++;
        if ({O_wr_cnt, O_pkt_cnt} !== {16'd19, 16'd10}) begin
            n_fail++;
            $display("FAIL wrap_counts: got %h expected %h", {O_wr_cnt, O_pkt_cnt}, {16'd19, 16'd10});
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] ed[3] = '{8'h12, 8'h13, 8'h30};
        logic [3:0] eg[3] = '{4'h2, 4'h2, 4'h8};
        int         ec[3] = '{1, 2, 4};
        int         guard = 0;
        clear_model();
        len[2] = 1;
        tick();
        tick();
        len[1] = 4;
        tick();
        tick();
        tick();
        n_tests++;
        if ({O_winc, O_grant} !== {1'b1, 4'b0010}) begin
            n_fail++;
            $display("FAIL rst_prepkt: got %h expected %h", {O_winc, O_grant}, {1'b1, 4'b0010});
        end
        #2;
        I_rst = 1'b1;
        #1;
        n_tests++;
        if ({O_grant, O_ack, O_winc, O_wdata, O_wr_cnt, O_pkt_cnt} !== 45'd0) begin
            n_fail++;
            $display("FAIL rst_async: got %h expected 0", {O_grant, O_ack, O_winc, O_wdata, O_wr_cnt, O_pkt_cnt});
        end
        @(negedge I_clk);
        n_tests++;
        if ({O_grant, O_winc} !== 5'd0) begin
            n_fail++;
            $display("FAIL rst_held: got %h expected 0", {O_grant, O_winc});
        end
        @(posedge I_clk);
        #1;
        I_rst = 1'b0;
        log_d.delete(); log_g.delete(); log_a.delete(); log_c.delete();
        cyc     = 0;
        sent[3] = 0;
        len[3]  = 1;
        while ((sent[1] < 4 || sent[3] < 1) && guard < 20) begin
            tick();
            guard++;
        end
        n_tests++;
        if (log_d.size() != 3) begin
            n_fail++;
            $display("FAIL rst_writes: got %0d expected 3", log_d.size());
        end
        for (int i = 0; i < 3; i++) begin
            if (i < log_d.size()) begin
                n_tests++;
                if ({log_g[i], log_a[i], log_d[i], 8'(log_c[i])} !== {eg[i], eg[i], ed[i], 8'(ec[i])}) begin
                    n_fail++;
                    $display("FAIL rst_beat%0d: got %h expected %h", i,
                             {log_g[i], log_a[i], log_d[i], 8'(log_c[i])}, {eg[i], eg[i], ed[i], 8'(ec[i])});
                end
            end
        end
        n_tests++;
        if ({O_wr_cnt, O_pkt_cnt} !== {16'd3, 16'd2}) begin
            n_fail++;
            $display("FAIL rst_counts: got %h expected %h", {O_wr_cnt, O_pkt_cnt}, {16'd3, 16'd2});
        end
    endtask

    task automatic test_counter_wrap();
        int guard = 0;
        bit seen  = 1'b0;
        clear_model();
        log_en = 1'b0;
        I_rst  = 1'b1;
        @(posedge I_clk);
        #1;
        I_rst  = 1'b0;
        len[0] = 65536;
        while (sent[0] < 65536 && guard < 70000) begin
            full = ((guard % 4096) == 100);
            tick();
            guard++;
            if (sent[0] == 65535 && !seen) begin
                seen = 1'b1;
                n_tests++;
                if (O_wr_cnt !== 16'hFFFF) begin
                    n_fail++;
                    $display("FAIL cnt_ffff: got %h expected ffff", O_wr_cnt);
                end
            end
        end
        full = 1'b0;
        n_tests++;
        if (sent[0] != 65536) begin
            n_fail++;
            $display("FAIL cnt_timeout: got %0d beats expected 65536", sent[0]);
        end
        n_tests++;
        if ({O_wr_cnt, O_pkt_cnt} !== {16'd0, 16'd1}) begin
            n_fail++;
            $display("FAIL cnt_wrap: got %h expected %h", {O_wr_cnt, O_pkt_cnt}, {16'd0, 16'd1});
        end
        n_tests++;
        if (viol != 0) begin
            n_fail++;
            $display("FAIL winc_while_full: got %0d expected 0", viol);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_full_stall();
        test_req_drop();
        test_ptr_wrap();
        test_async_reset();
        test_counter_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
